axi4_lite_wr_responder: RTL and testbench
=========================================

# axi4_lite_wr_responder

Slave-side responder for the AXI4-Lite write path: AW, W and B channels. It accepts a write address and write data in either order, commits one strobed write to the slave memory port, then returns a write response. It sits inside `axi4_lite_slave` as the counterpart to the read data path, and drives the same memory that read data is served from.

## Interface
Parameters:
- MEM_DEPTH, 4096: number of addressable memory words; only used by the range check.

Ports (Addr_Width, Data_Width from `axi4_lite_Defs`):
- ACLK  in  1  system clock; single clock domain.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  Addr_Width  write address.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address accepted.
- WDATA  in  Data_Width  write data.
- WSTRB  in  Data_Width/8  byte lane enables.
- WVALID  in  1  data valid.
- WREADY  out  1  data accepted.
- BRESP  out  2  write response (OKAY 2'b00, SLVERR 2'b10).
- BVALID  out  1  response valid.
- BREADY  in  1  master accepts response.
- mem_we  out  1  memory write strobe, one cycle per transaction.
- mem_addr  out  Addr_Width  memory address, equal to the captured AWADDR.
- mem_wdata  out  Data_Width  captured WDATA.
- mem_wstrb  out  Data_Width/8  captured WSTRB.

## Operation
- FSM states and their outputs:
  - IDLE: AWREADY=1, WREADY=1.
  - WAIT_W: address held; AWREADY=0, WREADY=1.
  - WAIT_AW: data held; AWREADY=1, WREADY=0.
  - WRITE: AWREADY=0, WREADY=0.
  - RESP: AWREADY=0, WREADY=0.
- Transitions:
  - IDLE: AW and W handshakes in the same cycle -> WRITE.
  - IDLE: AW handshake only -> WAIT_W.
  - IDLE: W handshake only -> WAIT_AW.
  - WAIT_W: W handshake -> WRITE.
  - WAIT_AW: AW handshake -> WRITE.
  - WRITE -> RESP, unconditionally.
  - RESP: BVALID && BREADY -> IDLE.
- Capture registers:
  - AWADDR is loaded on the AW handshake.
  - WDATA and WSTRB are loaded on the W handshake.
  - Both hold until the next capture.
- WRITE state:
  - mem_we=1 for exactly one cycle.
  - mem_* outputs are driven from the capture registers.
  - BRESP is computed and registered.
- RESP state:
  - BVALID stays high, and BRESP stays stable, until BREADY is sampled high.
  - BVALID never drops without a handshake.
- A master asserting WVALID before AWVALID is legal. So is asserting both together. Neither VALID may be required to wait on READY.
- WSTRB=0: mem_we still pulses with mem_wstrb=0, and BRESP=OKAY.

## Timing
- Reset values:
  - State=IDLE.
  - BVALID=0, BRESP=2'b00, mem_we=0.
  - Capture registers=0.
  - AWREADY=0 and WREADY=0 for as long as ARESET is high.
- Latency:
  - Let edge N be the edge where the later of the AW/W handshakes occurs.
  - mem_we is high in cycle N..N+1.
  - BVALID rises at edge N+1.
  - With BREADY held high, BVALID falls at edge N+2 and AWREADY/WREADY return high after N+2.
- Throughput: at most one write per 3 cycles.
- ARESET mid-transaction: the transaction is discarded.
  - Holds, state and BVALID clear immediately.
  - No mem_we is issued.
  - No response is owed after reset.

## Configuration
- AXI4L_WR_RANGE_CHECK_EN defined:
  - AWADDR >= MEM_DEPTH gives BRESP=SLVERR.
  - mem_we stays 0 in WRITE for that transaction.
  - All other timing is unchanged.
- AXI4L_WR_RANGE_CHECK_EN undefined:
  - BRESP is always OKAY.
  - mem_we always pulses.
  - Out-of-range addresses are passed through unchanged.

## Structure
- `axi4_lite_Defs` holds:
  - Addr_Width and Data_Width.
  - The resp_t enum (OKAY, EXOKAY, SLVERR, DECERR).
  - The wr_state_t FSM enum.
- Sub-module `axi4_lite_hold_reg`: a parameterised-width capture register with load and async clear. It is instantiated twice: once for the address, once for data+strobe.

## Test plan
- Simultaneous handshake:
  - Stimulus: AWADDR=32'hdef, WDATA=32'h87654321, WSTRB=4'hF, both VALIDs high in one cycle, BREADY=1.
  - Required: mem_we pulses once with matching address/data/strobe, BRESP=OKAY, BVALID high for exactly one cycle.
- Data before address:
  - Stimulus: WVALID 2 cycles ahead of AWVALID, AWADDR=32'h10, WDATA=32'hA5A5A5A5.
  - Required: WREADY is low while waiting in WAIT_AW; the write commits one edge after the AW handshake.
- Response backpressure:
  - Stimulus: BREADY held low for 4 cycles.
  - Required: BVALID and BRESP stay stable; AWREADY=WREADY=0 throughout; IDLE is entered the cycle after BREADY rises.
- Partial strobe:
  - Stimulus: WSTRB=4'b0101, WDATA=32'h11223344 to 32'h20.
  - Required: mem_wstrb=4'b0101.
  - Read-back of a location previously holding 32'hFFFFFFFF returns 32'hFF22FF44.
- Range check (macro defined, MEM_DEPTH=4096):
  - Stimulus: AWADDR=32'h1000.
  - Required: BRESP=2'b10, mem_we never asserts.
- Reset mid-operation:
  - Stimulus: ARESET pulsed while in WAIT_W with address 32'h44 held.
  - Required: no mem_we, BVALID=0, IDLE after reset.
  - A following write to 32'h44 completes normally.

Source files
------------

// File: rtl/axi4_lite_wr_responder_pkg.sv
// Shared widths, response codes and write-FSM states for the AXI4-Lite write responder.
package axi4_lite_Defs;

  localparam int Addr_Width = 32;
  localparam int Data_Width = 32;
  localparam int Strb_Width = Data_Width / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    WAIT_AW,
    WRITE,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi4_lite_wr_responder_if.sv
// AXI4-Lite write-path channels (AW, W, B) with master and slave views.
interface axi4_lite_wr_responder_if;
  import axi4_lite_Defs::*;

  logic [Addr_Width-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [Data_Width-1:0] WDATA;
  logic [Strb_Width-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi4_lite_wr_responder_hold_reg.sv
// Capture register: loads on a handshake, holds otherwise, cleared asynchronously.
module axi4_lite_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;

  always_comb hold_d = load ? d : hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign q = hold_q;

endmodule

// File: rtl/axi4_lite_wr_responder.sv
// AXI4-Lite write responder: AW/W in any order, one strobed memory write, then B.
// Optional address range check (SLVERR, write suppressed) enabled by AXI4L_WR_RANGE_CHECK_EN.
module axi4_lite_wr_responder
  import axi4_lite_Defs::*;
#(
  parameter int MEM_DEPTH = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi4_lite_wr_responder_if.slave s_axi,
  output logic                  mem_we,
  output logic [Addr_Width-1:0] mem_addr,
  output logic [Data_Width-1:0] mem_wdata,
  output logic [Strb_Width-1:0] mem_wstrb
);

`ifdef AXI4L_WR_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  localparam logic [Addr_Width-1:0] MEM_LIMIT = Addr_Width'(MEM_DEPTH);

  wr_state_t state_q, state_d;
  logic      awready_q, awready_d;
  logic      wready_q, wready_d;
  logic      bvalid_q, bvalid_d;
  resp_t     bresp_q, bresp_d;
  logic      mem_we_q, mem_we_d;

  logic aw_hs, w_hs, b_hs;
  logic [Addr_Width-1:0] addr_held;
  logic [Addr_Width-1:0] addr_next;
  logic                  addr_ok;

  assign aw_hs = s_axi.AWVALID && awready_q;
  assign w_hs  = s_axi.WVALID  && wready_q;
  assign b_hs  = bvalid_q      && s_axi.BREADY;

  axi4_lite_hold_reg #(.WIDTH(Addr_Width)) u_addr_hold (
    .clk  (ACLK),
    .rst  (ARESET),
    .load (aw_hs),
    .d    (s_axi.AWADDR),
    .q    (addr_held)
  );

  axi4_lite_hold_reg #(.WIDTH(Data_Width + Strb_Width)) u_data_hold (
    .clk  (ACLK),
    .rst  (ARESET),
    .load (w_hs),
    .d    ({s_axi.WDATA, s_axi.WSTRB}),
    .q    ({mem_wdata, mem_wstrb})
  );

  // mem_we is registered on the completing handshake edge, so the range decision
  // must look at the address being captured on that same edge.
  assign addr_next = aw_hs ? s_axi.AWADDR : addr_held;
  assign addr_ok   = !RANGE_CHECK || (addr_next < MEM_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = WRITE;
        else if (aw_hs)    state_d = WAIT_W;
        else if (w_hs)     state_d = WAIT_AW;
      end
      WAIT_W:  if (w_hs)  state_d = WRITE;
      WAIT_AW: if (aw_hs) state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (b_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    awready_d = (state_d == IDLE) || (state_d == WAIT_AW);
    wready_d  = (state_d == IDLE) || (state_d == WAIT_W);
    mem_we_d  = (state_d == WRITE) && addr_ok;
    bvalid_d  = (state_d == RESP);
    bresp_d   = bresp_q;
    if (state_q == WRITE) bresp_d = addr_ok ? OKAY : SLVERR;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = addr_held;

endmodule

// File: tb/tb_axi4_lite_wr_responder.sv
// Directed bench for axi4_lite_wr_responder; acts as the AXI master and as the slave memory.
module tb_axi4_lite_wr_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int we_count  = 0;
  logic [31:0] mem_model [logic [31:0]];

  axi4_lite_wr_responder_if bus ();

  axi4_lite_wr_responder #(.MEM_DEPTH(4096)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 ACLK = ~ACLK;

  // Slave memory model: applies byte strobes whenever the DUT commits a write.
  always @(posedge ACLK) begin
    if (mem_we) begin
      logic [31:0] word;
      we_count++;
      word = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
      mem_model[mem_addr] = word;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!(bus.AWREADY && bus.WREADY) && n < 20) begin
      step();
      n++;
    end
    ok = bus.AWREADY && bus.WREADY;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    bus.AWVALID = 0; bus.WVALID = 0; bus.BREADY = 0;
    bus.AWADDR = '0; bus.WDATA = '0; bus.WSTRB = '0;
    step(); step();
    total_cnt++; if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) $display("FAIL reset_ready: got AWREADY=%b WREADY=%b, required 0/0", bus.AWREADY, bus.WREADY); else pass_cnt++;
    total_cnt++; if (bus.BVALID !== 1'b0 || bus.BRESP !== 2'b00) $display("FAIL reset_b: got BVALID=%b BRESP=%b, required 0/00", bus.BVALID, bus.BRESP); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) $display("FAIL reset_mem: got we=%b addr=%h data=%h strb=%h, required all 0", mem_we, mem_addr, mem_wdata, mem_wstrb); else pass_cnt++;
    ARESET = 1'b0;
    step();
    total_cnt++; if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) $display("FAIL reset_idle: got AWREADY=%b WREADY=%b, required 1/1", bus.AWREADY, bus.WREADY); else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_simultaneous();
    bit ok;
    int we0;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL sim_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    we0 = we_count;
    bus.AWADDR = 32'hdef; bus.WDATA = 32'h87654321; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'hdef || mem_wdata !== 32'h87654321 || mem_wstrb !== 4'hF) $display("FAIL sim_mem: got we=%b addr=%h data=%h strb=%h, required 1/00000def/87654321/f", mem_we, mem_addr, mem_wdata, mem_wstrb); else pass_cnt++;
    total_cnt++; if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b0) $display("FAIL sim_write_state: got BVALID=%b AWREADY=%b, required 0/0", bus.BVALID, bus.AWREADY); else pass_cnt++;
    step();
    total_cnt++; if (mem_we !== 1'b0 || bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00) $display("FAIL sim_resp: got we=%b BVALID=%b BRESP=%b, required 0/1/00", mem_we, bus.BVALID, bus.BRESP); else pass_cnt++;
    step();
    total_cnt++; if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) $display("FAIL sim_done: got BVALID=%b AWREADY=%b WREADY=%b, required 0/1/1", bus.BVALID, bus.AWREADY, bus.WREADY); else pass_cnt++;
    total_cnt++; if (we_count - we0 !== 1) $display("FAIL sim_we_count: got %0d pulses, required 1", we_count - we0); else pass_cnt++;
    $display("write addr=00000def data=87654321 strb=f: done");
  endtask

  task automatic test_data_first();
    bit ok;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL df_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'hF; bus.WVALID = 1; bus.BREADY = 1;
    step();
    bus.WVALID = 0;
    total_cnt++; if (bus.WREADY !== 1'b0 || bus.AWREADY !== 1'b1 || mem_we !== 1'b0) $display("FAIL df_wait1: got WREADY=%b AWREADY=%b we=%b, required 0/1/0", bus.WREADY, bus.AWREADY, mem_we); else pass_cnt++;
    step();
    total_cnt++; if (bus.WREADY !== 1'b0 || bus.BVALID !== 1'b0 || mem_we !== 1'b0) $display("FAIL df_wait2: got WREADY=%b BVALID=%b we=%b, required 0/0/0", bus.WREADY, bus.BVALID, mem_we); else pass_cnt++;
    bus.AWADDR = 32'h10; bus.AWVALID = 1;
    step();
    bus.AWVALID = 0;
    total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hA5A5A5A5) $display("FAIL df_commit: got we=%b addr=%h data=%h, required 1/00000010/a5a5a5a5", mem_we, mem_addr, mem_wdata); else pass_cnt++;
    step();
    total_cnt++; if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00) $display("FAIL df_resp: got BVALID=%b BRESP=%b, required 1/00", bus.BVALID, bus.BRESP); else pass_cnt++;
    step();
    $display("write addr=00000010 data=a5a5a5a5 (data first): done");
  endtask

  task automatic test_backpressure();
    bit ok;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL bp_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    bus.AWADDR = 32'h30; bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 0;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++; if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) $display("FAIL bp_hold%0d: got BVALID=%b BRESP=%b AWREADY=%b WREADY=%b, required 1/00/0/0", i, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY); else pass_cnt++;
    end
    bus.BREADY = 1;
    step();
    total_cnt++; if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) $display("FAIL bp_release: got BVALID=%b AWREADY=%b WREADY=%b, required 0/1/1", bus.BVALID, bus.AWREADY, bus.WREADY); else pass_cnt++;
    $display("write addr=00000030 data=12345678 (B held 4 cycles): done");
  endtask

  task automatic test_partial_strobe();
    bit ok;
    mem_model[32'h20] = 32'hFFFFFFFF;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL ps_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    bus.AWADDR = 32'h20; bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    total_cnt++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b0101) $display("FAIL ps_strb: got we=%b strb=%b, required 1/0101", mem_we, mem_wstrb); else pass_cnt++;
    step();
    total_cnt++; if (mem_model[32'h20] !== 32'hFF22FF44) $display("FAIL ps_readback: got %h, required ff22ff44", mem_model[32'h20]); else pass_cnt++;
    step();
    $display("write addr=00000020 data=11223344 strb=0101: done");
  endtask

  task automatic test_zero_strobe();
    bit ok;
    int we0;
    mem_model[32'h50] = 32'h5A5A5A5A;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL zs_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    we0 = we_count;
    bus.AWADDR = 32'h50; bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'h0;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    total_cnt++; if (mem_we !== 1'b1 || mem_wstrb !== 4'h0) $display("FAIL zs_we: got we=%b strb=%b, required 1/0000", mem_we, mem_wstrb); else pass_cnt++;
    step();
    total_cnt++; if (bus.BRESP !== 2'b00 || mem_model[32'h50] !== 32'h5A5A5A5A || we_count - we0 !== 1) $display("FAIL zs_resp: got BRESP=%b word=%h pulses=%0d, required 00/5a5a5a5a/1", bus.BRESP, mem_model[32'h50], we_count - we0); else pass_cnt++;
    step();
    $display("write addr=00000050 strb=0000: done");
  endtask

  task automatic test_range_check();
    bit ok;
    int we0;
    logic [1:0] exp_resp;
    int exp_pulses;
`ifdef AXI4L_WR_RANGE_CHECK_EN
    exp_resp = 2'b10; exp_pulses = 0;
`else
    exp_resp = 2'b00; exp_pulses = 1;
`endif
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL rc_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    we0 = we_count;
    bus.AWADDR = 32'h1000; bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    step();
    total_cnt++; if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp) $display("FAIL rc_resp: got BVALID=%b BRESP=%b, required 1/%b", bus.BVALID, bus.BRESP, exp_resp); else pass_cnt++;
    step();
    total_cnt++; if (we_count - we0 !== exp_pulses) $display("FAIL rc_we: got %0d pulses, required %0d", we_count - we0, exp_pulses); else pass_cnt++;
    $display("write addr=00001000 (range boundary): done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int we0;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL rm_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    we0 = we_count;
    bus.AWADDR = 32'h44; bus.AWVALID = 1; bus.BREADY = 1;
    step();
    bus.AWVALID = 0;
    total_cnt++; if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b1 || mem_addr !== 32'h44) $display("FAIL rm_wait_w: got AWREADY=%b WREADY=%b addr=%h, required 0/1/00000044", bus.AWREADY, bus.WREADY, mem_addr); else pass_cnt++;
    ARESET = 1'b1;
    #1;
    total_cnt++; if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rm_async: got BVALID=%b AWREADY=%b WREADY=%b we=%b addr=%h, required 0/0/0/0/0", bus.BVALID, bus.AWREADY, bus.WREADY, mem_we, mem_addr); else pass_cnt++;
    step();
    ARESET = 1'b0;
    step(); step();
    total_cnt++; if (we_count !== we0 || bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) $display("FAIL rm_idle: got pulses=%0d BVALID=%b AWREADY=%b WREADY=%b, required 0/0/1/1", we_count - we0, bus.BVALID, bus.AWREADY, bus.WREADY); else pass_cnt++;
    bus.AWADDR = 32'h44; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    step();
    total_cnt++; if (mem_model[32'h44] !== 32'hCAFEF00D || bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00) $display("FAIL rm_after: got word=%h BVALID=%b BRESP=%b, required cafef00d/1/00", mem_model[32'h44], bus.BVALID, bus.BRESP); else pass_cnt++;
    step();
    $display("reset in WAIT_W then write addr=00000044 data=cafef00d: done");
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_ready(ok);
    total_cnt++; if (!ok) $display("FAIL bb_ready: got not ready, required ready within 20 cycles"); else pass_cnt++;
    bus.AWADDR = 32'h58; bus.WDATA = 32'h55555555; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 1;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    step();
    bus.AWADDR = 32'h60; bus.WDATA = 32'h66666666;
    bus.AWVALID = 1; bus.WVALID = 1;
    step();
    total_cnt++; if (mem_we !== 1'b0 || bus.AWREADY !== 1'b1 || mem_addr !== 32'h58) $display("FAIL bb_gap: got we=%b AWREADY=%b addr=%h, required 0/1/00000058", mem_we, bus.AWREADY, mem_addr); else pass_cnt++;
    step();
    bus.AWVALID = 0; bus.WVALID = 0;
    total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h60 || mem_wdata !== 32'h66666666) $display("FAIL bb_second: got we=%b addr=%h data=%h, required 1/00000060/66666666", mem_we, mem_addr, mem_wdata); else pass_cnt++;
    step(); step();
    $display("back-to-back writes 00000058, 00000060: done");
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_data_first();
    test_backpressure();
    test_partial_strobe();
    test_zero_strobe();
    test_range_check();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
